accum_mult_mod_pipe: RTL and testbench

//  Fully flow-controlled modular multiplier: o_dat = (i_dat_a * i_dat_b) mod M, one result/cycle.

---
 rtl/accum_mult_mod_pipe.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_accum_mult_mod_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_mult_mod_pipe.sv
// ---------------------------------------------------------------------------
// accum_mult_mod_pipe
//
// Fully flow-controlled modular multiplier: o_dat = (i_dat_a * i_dat_b) mod M,
// one result per cycle.
//
// How the result is formed:
//   - The 2*BITS product P is built from a grid of A_DSP_W x B_DSP_W partial
//     products, which are then summed.
//   - The upper half of P is folded back below 2^BITS. Each RAM_A_W-bit chunk
//     addresses a runtime-loaded table whose entry already holds that chunk's
//     weight reduced mod M.
//   - NUM_SUB conditional-subtract stages then bring the sum below M.
//
// All stages share one enable. Under back-pressure the whole pipe holds, so
// no result is lost or duplicated.
//
// Derived: NUM_TBL = ceil(BITS/RAM_A_W), NUM_SUB = NUM_TBL+1,
//          latency LAT = 5+NUM_SUB cycles from input transfer to o_val.
//
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_val / o_rdy   input handshake (operands i_dat_a, i_dat_b, both < M)
//   o_val / i_rdy   output handshake (result o_dat < M)
//   i_mod_we/i_mod  modulus load (M[BITS-1] must be 1)
//   i_ram_we, i_ram_sel, i_ram_addr, i_ram_d
//                   table k=i_ram_sel, entry v=i_ram_addr:
//                   (v << (BITS+k*RAM_A_W)) mod M
//   o_busy          some pipeline stage holds valid data
//   o_cfg_err       one-cycle pulse, a configuration write was rejected
//
// Optional feature macro: ACCUM_MULT_MOD_PIPE_TAG_EN
//   When defined, adds i_tag/o_tag (TAG_W bits). The tag travels alongside
//   its operands and is presented with the matching result.
// ---------------------------------------------------------------------------
module accum_mult_mod_pipe #(
  parameter int BITS    = 64,
  parameter int A_DSP_W = 26,
  parameter int B_DSP_W = 17,
  parameter int RAM_A_W = 8,
  parameter int TAG_W   = 8,
  localparam int NUM_TBL = (BITS + RAM_A_W - 1) / RAM_A_W,
  localparam int SEL_W   = (NUM_TBL > 1) ? $clog2(NUM_TBL) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_val,
  output logic               o_rdy,
  input  logic [BITS-1:0]    i_dat_a,
  input  logic [BITS-1:0]    i_dat_b,
  output logic               o_val,
  input  logic               i_rdy,
  output logic [BITS-1:0]    o_dat,
  input  logic               i_mod_we,
  input  logic [BITS-1:0]    i_mod,
  input  logic               i_ram_we,
  input  logic [SEL_W-1:0]   i_ram_sel,
  input  logic [RAM_A_W-1:0] i_ram_addr,
  input  logic [BITS-1:0]    i_ram_d,
  output logic               o_busy,
  output logic               o_cfg_err
`ifdef ACCUM_MULT_MOD_PIPE_TAG_EN
  ,
  input  logic [TAG_W-1:0]   i_tag,
  output logic [TAG_W-1:0]   o_tag
`endif
);

  localparam int NUM_SUB = NUM_TBL + 1;
  localparam int LAT     = 5 + NUM_SUB;
  localparam int NA      = (BITS + A_DSP_W - 1) / A_DSP_W;
  localparam int NB      = (BITS + B_DSP_W - 1) / B_DSP_W;
  localparam int PP_W    = A_DSP_W + B_DSP_W;
  localparam int P_W     = 2 * BITS;
  localparam int HI_W    = NUM_TBL * RAM_A_W;
  // The folded sum is below (NUM_TBL+2)*M, which sets this width.
  localparam int SW      = BITS + $clog2(NUM_TBL + 2) + 1;
  localparam int TBL_D   = 1 << RAM_A_W;
  localparam logic [SEL_W:0] NUM_TBL_C = (SEL_W + 1)'(NUM_TBL);

  // Control.
  logic             en_s;
  logic             in_xfer_s;
  logic             cfg_ok_s;
  logic             sel_ok_s;
  logic             mod_wr_s;
  logic             ram_wr_s;
  logic             cfg_err_s;
  logic [LAT-1:0]   vld_r;
  logic [LAT-1:0]   vld_nxt_s;
  logic             busy_r;
  logic             cfg_err_r;
  logic [BITS-1:0]  mod_r;
  logic [SW-1:0]    mod_ext_s;

  // Datapath.
  logic [BITS-1:0]        a_r;
  logic [BITS-1:0]        b_r;
  logic [NA*A_DSP_W-1:0]  a_pad_s;
  logic [NB*B_DSP_W-1:0]  b_pad_s;
  logic [PP_W-1:0]        pp_r [NA][NB];
  logic [P_W-1:0]         p_sum_s;
  logic [P_W-1:0]         p_r;
  logic [HI_W-1:0]        p_hi_s;
  logic [BITS-1:0]        plo_r;
  logic [BITS-1:0]        tbl_q_s [NUM_TBL];
  logic [SW-1:0]          s_sum_s;
  logic [SW-1:0]          s4_r;
  logic [SW-1:0]          sub_r [NUM_SUB-1];
  logic [BITS-1:0]        dat_r;

  // One reduction step: bring s down by M when it is not already below M.
  function automatic logic [SW-1:0] cond_sub(input logic [SW-1:0] s,
                                             input logic [SW-1:0] m);
    logic [SW-1:0] r;
    if (s >= m) begin
      r = s - m;
    end else begin
      r = s;
    end
    return r;
  endfunction

  // Global enable, handshake and configuration-write qualification.
  always_comb begin
    en_s      = ~vld_r[LAT-1] | i_rdy;
    in_xfer_s = i_val & en_s;
    // Writes only land while the pipe is empty and no operand is entering.
    // An accepted write is therefore seen by every later operand and by
    // no earlier one.
    cfg_ok_s  = ~busy_r & ~in_xfer_s;
    sel_ok_s  = ({1'b0, i_ram_sel} < NUM_TBL_C);
    mod_wr_s  = i_mod_we & cfg_ok_s;
    ram_wr_s  = i_ram_we & cfg_ok_s & sel_ok_s;
    cfg_err_s = (i_mod_we & ~cfg_ok_s) | (i_ram_we & ~(cfg_ok_s & sel_ok_s));
    if (en_s) begin
      vld_nxt_s = {vld_r[LAT-2:0], in_xfer_s};
    end else begin
      vld_nxt_s = vld_r;
    end
    mod_ext_s = SW'(mod_r);
  end

  assign o_rdy     = en_s;
  assign o_val     = vld_r[LAT-1];
  assign o_dat     = dat_r;
  assign o_busy    = busy_r;
  assign o_cfg_err = cfg_err_r;

  // Stage valids, busy flag (from next-state valids so it tracks vld_r
  // exactly) and config error pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_r     <= '0;
      busy_r    <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      vld_r     <= vld_nxt_s;
      busy_r    <= |vld_nxt_s;
      cfg_err_r <= cfg_err_s;
    end
  end

  // Modulus register; deliberately kept across reset.
  always_ff @(posedge i_clk) begin
    if (mod_wr_s) begin
      mod_r <= i_mod;
    end
  end

  // S0: operand capture.
  always_ff @(posedge i_clk) begin
    if (en_s) begin
      a_r <= i_dat_a;
      b_r <= i_dat_b;
    end
  end

  // Zero-extend operands to whole DSP slices.
  always_comb begin
    a_pad_s = (NA * A_DSP_W)'(a_r);
    b_pad_s = (NB * B_DSP_W)'(b_r);
  end

  // S1: DSP grid of partial products.
  always_ff @(posedge i_clk) begin
    if (en_s) begin
      for (int i = 0; i < NA; i++) begin
        for (int j = 0; j < NB; j++) begin
          pp_r[i][j] <= PP_W'(a_pad_s[i*A_DSP_W +: A_DSP_W]) *
                        PP_W'(b_pad_s[j*B_DSP_W +: B_DSP_W]);
        end
      end
    end
  end

  // Adder tree: align every partial product at its bit weight and sum.
  // Each term fits in P_W bits because the padding slices are zero.
  always_comb begin
    p_sum_s = '0;
    for (int i = 0; i < NA; i++) begin
      for (int j = 0; j < NB; j++) begin
        p_sum_s = p_sum_s + (P_W'(pp_r[i][j]) << (i * A_DSP_W + j * B_DSP_W));
      end
    end
  end

  // S2: full product register.
  always_ff @(posedge i_clk) begin
    if (en_s) begin
      p_r <= p_sum_s;
    end
  end

  // Upper product half, zero-padded so the last chunk is always full width.
  always_comb begin
    p_hi_s = HI_W'(p_r[P_W-1:BITS]);
  end

  // S3: lower product half travels beside the table reads.
  always_ff @(posedge i_clk) begin
    if (en_s) begin
      plo_r <= p_r[BITS-1:0];
    end
  end

  // One reduction table per upper-product chunk.
  for (genvar k = 0; k < NUM_TBL; k++) begin : g_tbl
    localparam logic [SEL_W-1:0] K_SEL = SEL_W'(k);
    logic [BITS-1:0] mem_r [TBL_D];
    logic [BITS-1:0] rd_q_r;

    // Table write port (configuration).
    always_ff @(posedge i_clk) begin
      if (ram_wr_s && (i_ram_sel == K_SEL)) begin
        mem_r[i_ram_addr] <= i_ram_d;
      end
    end

    // S3: synchronous table read addressed by this chunk of P.
    always_ff @(posedge i_clk) begin
      if (en_s) begin
        rd_q_r <= mem_r[p_hi_s[k*RAM_A_W +: RAM_A_W]];
      end
    end

    assign tbl_q_s[k] = rd_q_r;
  end

  // Fold: lower half plus all reduced upper chunks.
  always_comb begin
    s_sum_s = SW'(plo_r);
    for (int k = 0; k < NUM_TBL; k++) begin
      s_sum_s = s_sum_s + SW'(tbl_q_s[k]);
    end
  end

  // S4: folded sum register.
  always_ff @(posedge i_clk) begin
    if (en_s) begin
      s4_r <= s_sum_s;
    end
  end

  // S5 onward: all but the last conditional-subtract stage.
  always_ff @(posedge i_clk) begin
    if (en_s) begin
      sub_r[0] <= cond_sub(s4_r, mod_ext_s);
      for (int j = 1; j < NUM_SUB - 1; j++) begin
        sub_r[j] <= cond_sub(sub_r[j-1], mod_ext_s);
      end
    end
  end

  // Final subtract stage doubles as the output register; the value is now < M.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dat_r <= '0;
    end else if (en_s) begin
      dat_r <= BITS'(cond_sub(sub_r[NUM_SUB-2], mod_ext_s));
    end
  end

`ifdef ACCUM_MULT_MOD_PIPE_TAG_EN
  logic [TAG_W-1:0] tag_r [LAT];

  // Sideband tag shift line, advancing in lock-step with the valids.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < LAT; i++) begin
        tag_r[i] <= '0;
      end
    end else if (en_s) begin
      tag_r[0] <= i_tag;
      for (int i = 1; i < LAT; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  assign o_tag = tag_r[LAT-1];
`else
  // TAG_W only sizes the tag ports. It is referenced here so the tagless
  // build keeps the same parameter interface.
  if (TAG_W < 1) begin : g_no_tag_w
  end
`endif

endmodule

// File: tb/tb_accum_mult_mod_pipe.sv
`timescale 1ns/1ps
module tb_accum_mult_mod_pipe;

  localparam int BITS    = 64;
  localparam int NUM_TBL = 8;
  localparam int LAT     = 14;
  localparam int TAG_W   = 8;
  localparam logic [63:0] MOD_M = 64'hFFFF_FFFF_FFFF_FFC5; // 2^64-59

  logic            clk;
  logic            rst;
  logic            i_val;
  logic            o_rdy;
  logic [63:0]     dat_a;
  logic [63:0]     dat_b;
  logic            o_val;
  logic            i_rdy;
  logic [63:0]     o_dat;
  logic            mod_we;
  logic [63:0]     mod_v;
  logic            ram_we;
  logic [2:0]      ram_sel;
  logic [7:0]      ram_addr;
  logic [63:0]     ram_d;
  logic            o_busy;
  logic            o_cfg_err;
  logic [TAG_W-1:0] tag_in;
  logic [TAG_W-1:0] o_tag;

  // Second instance with BITS=52 (7 tables), so an out-of-range select
  // is reachable.
  logic            o_rdy2;
  logic            o_val2;
  logic [51:0]     o_dat2;
  logic            ram_we2;
  logic [2:0]      ram_sel2;
  logic            o_busy2;
  logic            o_cfg_err2;
  logic [TAG_W-1:0] o_tag2;

  int n_cmp = 0;
  int n_bad = 0;
  int n_push = 0;
  int n_pop = 0;
  logic sb_en;

  accum_mult_mod_pipe dut (
    .i_clk(clk), .i_rst(rst), .i_val(i_val), .o_rdy(o_rdy),
    .i_dat_a(dat_a), .i_dat_b(dat_b), .o_val(o_val), .i_rdy(i_rdy),
    .o_dat(o_dat), .i_mod_we(mod_we), .i_mod(mod_v), .i_ram_we(ram_we),
    .i_ram_sel(ram_sel), .i_ram_addr(ram_addr), .i_ram_d(ram_d),
    .o_busy(o_busy), .o_cfg_err(o_cfg_err)
`ifdef ACCUM_MULT_MOD_PIPE_TAG_EN
    , .i_tag(tag_in), .o_tag(o_tag)
`endif
  );

  accum_mult_mod_pipe #(.BITS(52)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_val(1'b0), .o_rdy(o_rdy2),
    .i_dat_a(52'd0), .i_dat_b(52'd0), .o_val(o_val2), .i_rdy(1'b1),
    .o_dat(o_dat2), .i_mod_we(1'b0), .i_mod(52'd0), .i_ram_we(ram_we2),
    .i_ram_sel(ram_sel2), .i_ram_addr(8'd0), .i_ram_d(52'd0),
    .o_busy(o_busy2), .o_cfg_err(o_cfg_err2)
`ifdef ACCUM_MULT_MOD_PIPE_TAG_EN
    , .i_tag(8'd0), .o_tag(o_tag2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain modular arithmetic.
  function automatic logic [63:0] mulmod(input logic [63:0] x, input logic [63:0] y);
    logic [127:0] p;
    p = 128'(x) * 128'(y);
    return 64'(p % {64'd0, MOD_M});
  endfunction

  function automatic logic [63:0] tbl_entry(input int k, input logic [7:0] v);
    logic [191:0] t;
    t = 192'(v) << (64 + 8 * k);
    return 64'(t % {128'd0, MOD_M});
  endfunction

  function automatic logic [63:0] rnd_op();
    logic [63:0] v;
    v = {$urandom, $urandom};
    if (v >= MOD_M) v = v - MOD_M;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard and hold monitor, sampled on the falling edge.
  typedef struct packed {
    logic [63:0]      dat;
    logic [TAG_W-1:0] tag;
  } exp_t;
  exp_t sb_q[$];
  logic hold_pend = 1'b0;
  logic [63:0] hold_dat;
  logic [TAG_W-1:0] hold_tag;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb_q.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_val", o_val, 1'b1);
        chk("hold_dat", o_dat, hold_dat);
`ifdef ACCUM_MULT_MOD_PIPE_TAG_EN
        chk("hold_tag", o_tag, hold_tag);
`endif
      end
      if (sb_en && o_val && i_rdy) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 128'(sb_q.size()), 128'(1));
        end else begin
          e = sb_q.pop_front();
          n_pop++;
          chk("sb_dat", o_dat, e.dat);
`ifdef ACCUM_MULT_MOD_PIPE_TAG_EN
          chk("sb_tag", o_tag, e.tag);
`endif
        end
      end
      if (sb_en && i_val && o_rdy) begin
        e.dat = mulmod(dat_a, dat_b);
        e.tag = tag_in;
        sb_q.push_back(e);
        n_push++;
      end
      hold_pend = o_val && !i_rdy;
      hold_dat  = o_dat;
      hold_tag  = o_tag;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single operation with exact-latency check.
  task automatic run_lat(input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    i_val = 1'b1; dat_a = a; dat_b = b; tag_in = 8'($urandom);
    tick();
    i_val = 1'b0;
    for (int c = 1; c < LAT; c++) begin
      if (c == LAT - 1) chk("lat_early", o_val, 1'b0);
      tick();
    end
    chk("lat_val", o_val, 1'b1);
    chk("lat_dat", o_dat, exp);
    tick();
  endtask

  task automatic drain();
    int c;
    c = 0;
    i_rdy = 1'b1;
    while ((sb_q.size() != 0 || o_busy) && c < 300) begin
      tick();
      c++;
    end
    chk("drain_timeout", 128'(c >= 300), 128'(0));
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;
  vec_t vt[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, q0, quiet;
    vt[0] = '{64'd3, 64'd5, 64'd15};
    vt[1] = '{MOD_M - 64'd1, MOD_M - 64'd1, 64'd1};
    vt[2] = '{64'h8000_0000_0000_0000, 64'd2, 64'd59};
    vt[3] = '{64'd0, MOD_M - 64'd1, 64'd0};
    vt[4] = '{64'd1, MOD_M - 64'd1, MOD_M - 64'd1};
    vt[5] = '{MOD_M - 64'd1, 64'd2, MOD_M - 64'd2};
    vt[6] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vt[7] = '{64'h1_0000_0000, 64'h1_0000_0000, 64'd59};

    sb_en = 1'b1;
    rst = 1'b1; i_val = 1'b0; dat_a = '0; dat_b = '0; i_rdy = 1'b1;
    mod_we = 1'b0; mod_v = '0; ram_we = 1'b0; ram_sel = '0; ram_addr = '0;
    ram_d = '0; tag_in = '0; ram_we2 = 1'b0; ram_sel2 = '0;
    repeat (3) tick();
    chk("rst_val", o_val, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_cfg_err", o_cfg_err, 1'b0);
    chk("rst_dat", o_dat, 64'd0);
    chk("rst_rdy", o_rdy, 1'b1);
    rst = 1'b0;

    // Load modulus (together with the first table write) and all tables.
    mod_we = 1'b1; mod_v = MOD_M;
    for (int k = 0; k < NUM_TBL; k++) begin
      for (int v = 0; v < 256; v++) begin
        ram_we = 1'b1; ram_sel = 3'(k); ram_addr = 8'(v); ram_d = tbl_entry(k, 8'(v));
        tick();
        mod_we = 1'b0;
      end
    end
    ram_we = 1'b0;
    chk("load_cfg_err", o_cfg_err, 1'b0);

    // Directed vectors with exact latency.
    for (int i = 0; i < 8; i++) run_lat(vt[i].a, vt[i].b, vt[i].exp);

    // Back-to-back random stream.
    p0 = n_pop;
    for (int n = 0; n < 1000; n++) begin
      i_val = 1'b1; dat_a = rnd_op(); dat_b = rnd_op(); tag_in = 8'($urandom);
      chk("b2b_rdy", o_rdy, 1'b1);
      tick();
    end
    i_val = 1'b0;
    drain();
    chk("b2b_count", 128'(n_pop - p0), 128'(1000));

    // Random back-pressure.
    p0 = n_pop; q0 = n_push;
    for (int n = 0; n < 600; n++) begin
      i_rdy = ($urandom_range(0, 1) == 1);
      i_val = ($urandom_range(0, 9) < 7);
      dat_a = rnd_op(); dat_b = rnd_op(); tag_in = 8'($urandom);
      tick();
    end
    i_val = 1'b0;
    drain();
    chk("stall_count", 128'(n_pop - p0), 128'(n_push - q0));

    // Configuration writes while busy are rejected.
    i_val = 1'b1; dat_a = 64'd3; dat_b = 64'd5;
    tick();
    i_val = 1'b0;
    ram_we = 1'b1; ram_sel = 3'd0; ram_addr = 8'd1; ram_d = 64'd12345;
    tick();
    ram_we = 1'b0;
    chk("busy_ram_err", o_cfg_err, 1'b1);
    mod_we = 1'b1; mod_v = 64'h123;
    tick();
    mod_we = 1'b0;
    chk("busy_mod_err", o_cfg_err, 1'b1);
    tick();
    chk("err_pulse_end", o_cfg_err, 1'b0);
    drain();
    run_lat(64'h8000_0000_0000_0000, 64'd2, 64'd59);

    // Write coinciding with an input transfer is rejected.
    i_val = 1'b1; dat_a = 64'd7; dat_b = 64'd9;
    ram_we = 1'b1; ram_sel = 3'd0; ram_addr = 8'd1; ram_d = 64'd12345;
    tick();
    i_val = 1'b0; ram_we = 1'b0;
    chk("xfer_ram_err", o_cfg_err, 1'b1);
    drain();
    run_lat(64'h8000_0000_0000_0000, 64'd2, 64'd59);

    // Legal write is seen by the very next operand; then restore.
    sb_en = 1'b0;
    ram_we = 1'b1; ram_sel = 3'd0; ram_addr = 8'd1; ram_d = 64'd12345;
    tick();
    ram_we = 1'b0;
    chk("legal_no_err", o_cfg_err, 1'b0);
    run_lat(64'h8000_0000_0000_0000, 64'd2, 64'd12345);
    ram_we = 1'b1; ram_d = 64'd59;
    tick();
    ram_we = 1'b0;
    sb_en = 1'b1;
    run_lat(64'h8000_0000_0000_0000, 64'd2, 64'd59);

    // Out-of-range table select (7 tables in the 52-bit instance).
    ram_we2 = 1'b1; ram_sel2 = 3'd7;
    tick();
    chk("sel_range_err", o_cfg_err2, 1'b1);
    ram_sel2 = 3'd6;
    tick();
    ram_we2 = 1'b0;
    chk("sel_ok_no_err", o_cfg_err2, 1'b0);

    // Reset with five operations in flight.
    for (int n = 0; n < 5; n++) begin
      i_val = 1'b1; dat_a = rnd_op(); dat_b = rnd_op();
      tick();
    end
    i_val = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_val", o_val, 1'b0);
    chk("midrst_busy", o_busy, 1'b0);
    quiet = 0;
    for (int c = 0; c < LAT + 2; c++) begin
      if (o_val) quiet++;
      tick();
    end
    chk("midrst_quiet", 128'(quiet), 128'(0));
    run_lat(64'd7, 64'd9, 64'd63);
    run_lat(MOD_M - 64'd1, MOD_M - 64'd1, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
